// File: rtl/wb_commit_tracer_pkg.sv
// Shared definitions for the WB commit tracer: default depth, entry field widths, entry layout.
package wb_commit_tracer_pkg;

  localparam int unsigned TRACE_DEPTH   = 16;
  localparam int unsigned TRACE_DATA_W  = 32;
  localparam int unsigned TRACE_RD_W    = 5;
  localparam int unsigned TRACE_PC_W    = 32;
  localparam int unsigned TRACE_ENTRY_W = TRACE_PC_W + TRACE_RD_W + TRACE_DATA_W;

  // Entry layout, MSB first: {pc, rd, data}
  typedef struct packed {
    logic [TRACE_PC_W-1:0]   pc;
    logic [TRACE_RD_W-1:0]   rd;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/wb_commit_tracer_trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with registered head, valid and level.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic [PW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_bypass;

  assign empty_c   = (r_wr_ptr == r_rd_ptr);
  assign full_c    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop_ok  = pop & ~empty_c;
  assign w_push_ok = push & (~full_c | w_pop_ok);
  assign w_wr_nxt  = r_wr_ptr + PW'(w_push_ok);
  assign w_rd_nxt  = r_rd_ptr + PW'(w_pop_ok);
  // Entry being written this edge becomes the new head when it lands at the next read slot
  assign w_bypass  = w_push_ok && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_level  <= '0;
      r_dout   <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_valid  <= (w_wr_nxt != w_rd_nxt);
      r_level  <= w_wr_nxt - w_rd_nxt;
      r_dout   <= w_bypass ? din : r_mem[w_rd_nxt[AW-1:0]];
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign level = r_level;

endmodule

// File: rtl/wb_commit_tracer.sv
// Records every architectural register-file commit from the WB stage into a FWFT trace buffer.
module wb_commit_tracer
  import wb_commit_tracer_pkg::*;
#(
  parameter int unsigned DEPTH  = TRACE_DEPTH,
  parameter int unsigned DATA_W = TRACE_DATA_W,
  parameter int unsigned RD_W   = TRACE_RD_W,
  parameter int unsigned PC_W   = TRACE_PC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid,
  input  logic                   wb_reg_write,
  input  logic [RD_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [PC_W-1:0]        wb_pc,
  input  logic                   clear,
  input  logic                   trace_ready,
  output logic                   trace_valid,
  output logic [PC_W-1:0]        trace_pc,
  output logic [RD_W-1:0]        trace_rd,
  output logic [DATA_W-1:0]      trace_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [31:0]            commit_cnt
);

  localparam int unsigned EW = PC_W + RD_W + DATA_W;

  logic          w_commit;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic [EW-1:0] w_din;
  logic [EW-1:0] w_dout;
  logic          r_overflow;
  logic [31:0]   r_commit_cnt;

  // Writes to the zero register are architecturally invisible and never traced
  assign w_commit = wb_valid & wb_reg_write & (wb_rd != '0);
  assign w_drop   = w_commit & w_full & ~(trace_ready & ~w_empty);
  assign w_din    = {wb_pc, wb_rd, wb_data};

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear),
    .push    (w_commit & ~clear),
    .pop     (trace_ready),
    .din     (w_din),
    .dout    (w_dout),
    .valid   (trace_valid),
    .full_c  (w_full),
    .empty_c (w_empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_overflow   <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      r_commit_cnt <= r_commit_cnt + 32'(w_commit);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign trace_pc   = w_dout[EW-1 -: PC_W];
  assign trace_rd   = w_dout[DATA_W +: RD_W];
  assign trace_data = w_dout[DATA_W-1:0];
  assign overflow   = r_overflow;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_wb_commit_tracer.sv
// Directed plus randomized bench for wb_commit_tracer against a queue-based reference model.
module tb_wb_commit_tracer;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        clear;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [4:0]  level;
  logic        overflow;
  logic [31:0] commit_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {pc,rd,data}, sticky drop flag, commit counter
  logic [68:0] q[$];
  bit          m_ovf;
  logic [31:0] m_cnt;

  wb_commit_tracer dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_pc        (wb_pc),
    .clear        (clear),
    .trace_ready  (trace_ready),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_rd     (trace_rd),
    .trace_data   (trace_data),
    .level        (level),
    .overflow     (overflow),
    .commit_cnt   (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit c, popd, full;
    if (rst || clear) begin
      q.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      c    = wb_valid && wb_reg_write && (wb_rd != 5'd0);
      full = (q.size() == DEPTH);
      popd = trace_ready && (q.size() != 0);
      if (c) m_cnt = m_cnt + 32'd1;
      if (popd) void'(q.pop_front());
      if (c) begin
        if (!full || popd) q.push_back({wb_pc, wb_rd, wb_data});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("valid", 69'(trace_valid), 69'(q.size() != 0));
    if (q.size() != 0) chk("head", {trace_pc, trace_rd, trace_data}, q[0]);
    chk("level", 69'(level), 69'(q.size()));
    chk("overflow", 69'(overflow), 69'(m_ovf));
    chk("commit_cnt", 69'(commit_cnt), 69'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_wb(input logic v, input logic w, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] pc);
    wb_valid = v; wb_reg_write = w; wb_rd = rd; wb_data = data; wb_pc = pc;
  endtask

  task automatic idle();
    set_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    rst = 1'b1; clear = 1'b0; trace_ready = 1'b0;
    idle();
    m_ovf = 1'b0; m_cnt = '0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 69'(trace_valid), 69'(0));
    chk("rst_level", 69'(level), 69'(0));
    chk("rst_ovf", 69'(overflow), 69'(0));
    chk("rst_cnt", 69'(commit_cnt), 69'(0));
    chk("rst_trace", {trace_pc, trace_rd, trace_data}, 69'(0));
    rst = 1'b0;

    // Single commit, held while not ready, then popped
    set_wb(1'b1, 1'b1, 5'd8, 32'h1234, 32'h4);
    tick(); idle();
    chk("one_valid", 69'(trace_valid), 69'(1));
    chk("one_entry", {trace_pc, trace_rd, trace_data}, {32'h4, 5'd8, 32'h1234});
    chk("one_level", 69'(level), 69'(1));
    for (int i = 0; i < 5; i++) tick();
    chk("hold_entry", {trace_pc, trace_rd, trace_data}, {32'h4, 5'd8, 32'h1234});
    trace_ready = 1'b1; tick(); trace_ready = 1'b0;
    chk("pop_valid", 69'(trace_valid), 69'(0));
    chk("pop_level", 69'(level), 69'(0));

    // Writes to x0 and bubbles are not commits
    set_wb(1'b1, 1'b1, 5'd0, 32'hdead, 32'h8); tick();
    set_wb(1'b0, 1'b1, 5'd5, 32'hbeef, 32'hc); tick();
    set_wb(1'b1, 1'b0, 5'd6, 32'hcafe, 32'h10); tick();
    idle(); tick();
    chk("x0_level", 69'(level), 69'(0));
    chk("x0_cnt", 69'(commit_cnt), 69'(1));

    // Overflow: DEPTH+3 commits with no reader
    do_clear();
    for (int i = 0; i < DEPTH + 3; i++) begin
      set_wb(1'b1, 1'b1, 5'(i + 1), $urandom, 32'(i * 4)); tick();
    end
    idle(); tick();
    chk("ovf_level", 69'(level), 69'(16));
    chk("ovf_flag", 69'(overflow), 69'(1));
    chk("ovf_cnt", 69'(commit_cnt), 69'(19));
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_pc = 32'(i * 4);
      chk("drain_pc", 69'(trace_pc), 69'(exp_pc));
      tick();
    end
    chk("drain_empty", 69'(trace_valid), 69'(0));
    trace_ready = 1'b0;

    // Full with simultaneous pop accepts the new entry
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      set_wb(1'b1, 1'b1, 5'd3, $urandom, 32'(i)); tick();
    end
    set_wb(1'b1, 1'b1, 5'd9, 32'h55, 32'h100); trace_ready = 1'b1; tick();
    idle(); trace_ready = 1'b0;
    chk("fullpop_level", 69'(level), 69'(16));
    chk("fullpop_ovf", 69'(overflow), 69'(0));
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("fullpop_last", 69'(trace_pc), 69'(32'h100));
      tick();
    end
    trace_ready = 1'b0;

    // Clear beats a coincident commit
    for (int i = 0; i < 8; i++) begin
      set_wb(1'b1, 1'b1, 5'd4, $urandom, 32'(i + 32)); tick();
    end
    set_wb(1'b1, 1'b1, 5'd7, 32'h77, 32'h300); clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_level", 69'(level), 69'(0));
    chk("clr_cnt", 69'(commit_cnt), 69'(0));
    chk("clr_ovf", 69'(overflow), 69'(0));
    chk("clr_valid", 69'(trace_valid), 69'(0));
    set_wb(1'b1, 1'b1, 5'd2, 32'h22, 32'h200); tick(); idle(); tick();
    chk("clr_next_pc", 69'(trace_pc), 69'(32'h200));
    chk("clr_next_level", 69'(level), 69'(1));

    // Randomized traffic including rare clear/reset
    for (int i = 0; i < 3000; i++) begin
      set_wb(($urandom % 4) != 0, ($urandom % 5) != 0, 5'($urandom_range(0, 31)),
             $urandom, $urandom);
      trace_ready = (($urandom % 3) == 0) || (i > 1500 && ($urandom % 2) == 0);
      clear = (($urandom % 250) == 0);
      rst   = (($urandom % 400) == 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
